// File: rtl/sqrt_req_scheduler_pkg.sv
// Shared types and widths for the square-root engine scheduler.
package sqrt_req_scheduler_pkg;

   typedef enum logic [2:0] {
      SCH_IDLE,
      SCH_CLR,
      SCH_LOAD,
      SCH_RUN,
      SCH_DONE
   } sch_state_e;

   localparam int SQRT_IN_W  = 8;
   localparam int SQRT_OUT_W = 4;
   localparam int RSP_ID_W   = 3;

endpackage

// File: rtl/sqrt_req_scheduler_rr_arbiter_nreq.sv
// Combinational round-robin pick: first request scanning upward from last_grant+1, wrapping.
module rr_arbiter_nreq
   import sqrt_req_scheduler_pkg::*;
#(
   parameter int NREQ = 4
) (
   input  logic [NREQ-1:0]     req,
   input  logic [RSP_ID_W-1:0] last_grant,
   output logic [NREQ-1:0]     grant,
   output logic [RSP_ID_W-1:0] grant_id,
   output logic                any_req
);

   logic found;

   always_comb begin
      grant    = '0;
      grant_id = '0;
      found    = 1'b0;
      any_req  = |req;
      // k is the distance past the last winner, so k=NREQ revisits the last winner itself
      for (int k = 1; k <= NREQ; k++) begin
         for (int i = 0; i < NREQ; i++) begin
            if (!found && req[i] && (i == ((int'(last_grant) + k) % NREQ))) begin
               found    = 1'b1;
               grant[i] = 1'b1;
               grant_id = RSP_ID_W'(i);
            end
         end
      end
   end

endmodule

// File: rtl/sqrt_req_scheduler.sv
// Shares one 8-bit square-root engine between NREQ requesters: round-robin pick,
// then clear / load / run / capture with a run-length timeout.
module sqrt_req_scheduler
   import sqrt_req_scheduler_pkg::*;
#(
   parameter int NREQ     = 4,
   parameter int LOAD_CYC = 2,
   parameter int TIMEOUT  = 128
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic [NREQ-1:0]            req,
   input  logic [SQRT_IN_W*NREQ-1:0]  req_data,
   output logic [NREQ-1:0]            ack,
   output logic                       rsp_valid,
   output logic [RSP_ID_W-1:0]        rsp_id,
   output logic [SQRT_OUT_W-1:0]      rsp_root,
   output logic                       rsp_err,
   output logic                       busy,
   output logic [SQRT_IN_W-1:0]       eng_in,
   output logic                       eng_go,
   output logic                       eng_reset,
   input  logic                       eng_over,
   input  logic [SQRT_OUT_W-1:0]      eng_out
);

   localparam int RUN_W  = $clog2(TIMEOUT);
   localparam int LOAD_W = $clog2(LOAD_CYC + 1);
   localparam logic [RUN_W-1:0]    RUN_LAST   = RUN_W'(TIMEOUT - 1);
   localparam logic [LOAD_W-1:0]   LOAD_LAST  = LOAD_W'(LOAD_CYC - 1);
   localparam logic [RSP_ID_W-1:0] GRANT_INIT = RSP_ID_W'(NREQ - 1);

   sch_state_e            state_q, state_d;
   logic [RSP_ID_W-1:0]   last_grant_q, last_grant_d;
   logic [RSP_ID_W-1:0]   win_id_q, win_id_d;
   logic [SQRT_IN_W-1:0]  win_data_q, win_data_d;
   logic [LOAD_W-1:0]     load_cnt_q, load_cnt_d;
   logic [RUN_W-1:0]      run_cnt_q, run_cnt_d;
   logic [RSP_ID_W-1:0]   rsp_id_q, rsp_id_d;
   logic [SQRT_OUT_W-1:0] rsp_root_q, rsp_root_d;
   logic                  rsp_err_q, rsp_err_d;

   logic [NREQ-1:0]      arb_grant;
   logic [RSP_ID_W-1:0]  arb_id;
   logic                 arb_any;
   logic [SQRT_IN_W-1:0] arb_data;

   rr_arbiter_nreq #(.NREQ(NREQ)) u_arb (
      .req        (req),
      .last_grant (last_grant_q),
      .grant      (arb_grant),
      .grant_id   (arb_id),
      .any_req    (arb_any)
   );

   always_comb begin
      arb_data = '0;
      for (int i = 0; i < NREQ; i++) begin
         if (arb_grant[i]) arb_data = req_data[i*SQRT_IN_W +: SQRT_IN_W];
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q      <= SCH_IDLE;
         last_grant_q <= GRANT_INIT;
         win_id_q     <= '0;
         win_data_q   <= '0;
         load_cnt_q   <= '0;
         run_cnt_q    <= '0;
         rsp_id_q     <= '0;
         rsp_root_q   <= '0;
         rsp_err_q    <= 1'b0;
      end else begin
         state_q      <= state_d;
         last_grant_q <= last_grant_d;
         win_id_q     <= win_id_d;
         win_data_q   <= win_data_d;
         load_cnt_q   <= load_cnt_d;
         run_cnt_q    <= run_cnt_d;
         rsp_id_q     <= rsp_id_d;
         rsp_root_q   <= rsp_root_d;
         rsp_err_q    <= rsp_err_d;
      end
   end

   always_comb begin
      state_d      = state_q;
      last_grant_d = last_grant_q;
      win_id_d     = win_id_q;
      win_data_d   = win_data_q;
      load_cnt_d   = load_cnt_q;
      run_cnt_d    = run_cnt_q;
      rsp_id_d     = rsp_id_q;
      rsp_root_d   = rsp_root_q;
      rsp_err_d    = rsp_err_q;
      case (state_q)
         SCH_IDLE: begin
            if (arb_any) begin
               win_id_d     = arb_id;
               win_data_d   = arb_data;
               last_grant_d = arb_id;
               state_d      = SCH_CLR;
            end
         end
         SCH_CLR: begin
            load_cnt_d = '0;
            state_d    = SCH_LOAD;
         end
         SCH_LOAD: begin
            if (load_cnt_q == LOAD_LAST) begin
               run_cnt_d = '0;
               state_d   = SCH_RUN;
            end else begin
               load_cnt_d = load_cnt_q + LOAD_W'(1);
            end
         end
         SCH_RUN: begin
            // completion is checked first so a result on the last allowed cycle is kept
            if (eng_over) begin
               rsp_root_d = eng_out;
               rsp_err_d  = 1'b0;
               rsp_id_d   = win_id_q;
               state_d    = SCH_DONE;
            end else if (run_cnt_q == RUN_LAST) begin
               rsp_root_d = '0;
               rsp_err_d  = 1'b1;
               rsp_id_d   = win_id_q;
               state_d    = SCH_DONE;
            end else begin
               run_cnt_d = run_cnt_q + RUN_W'(1);
            end
         end
         SCH_DONE: state_d = SCH_IDLE;
         default:  state_d = SCH_IDLE;
      endcase
   end

   always_comb begin
      ack = '0;
      for (int i = 0; i < NREQ; i++) begin
         if ((state_q == SCH_DONE) && (win_id_q == RSP_ID_W'(i))) ack[i] = 1'b1;
      end
   end

   assign rsp_valid = (state_q == SCH_DONE);
   assign rsp_id    = rsp_id_q;
   assign rsp_root  = rsp_root_q;
   assign rsp_err   = rsp_err_q;
   assign busy      = (state_q != SCH_IDLE);
   assign eng_go    = (state_q == SCH_RUN);
   assign eng_in    = ((state_q == SCH_CLR) || (state_q == SCH_LOAD) || (state_q == SCH_RUN))
                      ? win_data_q : '0;
   assign eng_reset = reset || (state_q == SCH_CLR);

endmodule

// File: tb/tb_sqrt_req_scheduler.sv
// Directed bench for sqrt_req_scheduler with a behavioural engine model.
module tb_sqrt_req_scheduler;

   localparam int NREQ     = 4;
   localparam int LOAD_CYC = 2;
   localparam int TIMEOUT  = 16;

   logic            clk = 1'b0;
   logic            reset;
   logic [3:0]      req;
   logic [31:0]     req_data;
   logic [3:0]      ack;
   logic            rsp_valid;
   logic [2:0]      rsp_id;
   logic [3:0]      rsp_root;
   logic            rsp_err;
   logic            busy;
   logic [7:0]      eng_in;
   logic            eng_go;
   logic            eng_reset;
   logic            eng_over;
   logic [3:0]      eng_out;

   int n_chk  = 0;
   int n_fail = 0;

   int e_cnt;
   int e_lat    = 5;
   bit e_force9 = 1'b0;

   sqrt_req_scheduler #(.NREQ(NREQ), .LOAD_CYC(LOAD_CYC), .TIMEOUT(TIMEOUT)) dut (
      .clk       (clk),
      .reset     (reset),
      .req       (req),
      .req_data  (req_data),
      .ack       (ack),
      .rsp_valid (rsp_valid),
      .rsp_id    (rsp_id),
      .rsp_root  (rsp_root),
      .rsp_err   (rsp_err),
      .busy      (busy),
      .eng_in    (eng_in),
      .eng_go    (eng_go),
      .eng_reset (eng_reset),
      .eng_over  (eng_over),
      .eng_out   (eng_out)
   );

   always #5 clk = ~clk;

   function automatic logic [3:0] isqrt(input logic [7:0] x);
      int r = 0;
      while ((r + 1) * (r + 1) <= int'(x)) r++;
      return 4'(r);
   endfunction

   // engine: raises over after e_lat go cycles, cleared by eng_reset
   always @(posedge clk) begin
      if (eng_reset) begin
         e_cnt    <= 0;
         eng_over <= 1'b0;
         eng_out  <= 4'd0;
      end else if (eng_go && !eng_over) begin
         e_cnt <= e_cnt + 1;
         if (e_cnt + 1 == e_lat) begin
            eng_over <= 1'b1;
            eng_out  <= e_force9 ? 4'd9 : isqrt(eng_in);
         end
      end
   end

   task automatic chk(input string name, input int act, input int exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   // Waits for the next response and checks it, its timing and the idle cycle after it.
   task automatic do_job(input int exp_id, input int exp_root, input int exp_err,
                         input int exp_run, input bit hold);
      int n = 0, rst_cnt = 0, go_n = -1, clr_n = -1;
      bit got = 1'b0;
      while (n < 300 && !got) begin
         @(negedge clk);
         n++;
         if (eng_reset && !reset && go_n < 0) begin
            rst_cnt++;
            clr_n = n;
         end
         if (eng_go && go_n < 0) go_n = n;
         if (rsp_valid) got = 1'b1;
      end
      chk("rsp_seen", int'(got), 1);
      if (got) begin
         chk("ack_onehot", int'(ack), 1 << exp_id);
         chk("rsp_id", int'(rsp_id), exp_id);
         chk("rsp_root", int'(rsp_root), exp_root);
         chk("rsp_err", int'(rsp_err), exp_err);
         chk("go_low_done", int'(eng_go), 0);
         chk("busy_done", int'(busy), 1);
         chk("eng_reset_pulses", rst_cnt, 1);
         chk("clr_to_run", go_n - clr_n, 1 + LOAD_CYC);
         chk("run_to_done", n - go_n, exp_run);
         if (!hold) req[exp_id] = 1'b0;
         @(negedge clk);
         chk("valid_single", int'(rsp_valid), 0);
         chk("ack_single", int'(ack), 0);
         chk("busy_idle", int'(busy), 0);
         chk("root_hold", int'(rsp_root), exp_root);
      end
   endtask

   typedef struct {
      logic [3:0] set_req;
      logic [7:0] d0, d1, d2, d3;
      int         exp_id;
      int         exp_root;
      bit         hold;
   } vec_t;

   vec_t vecs[11];

   initial begin
      int wn;
      vecs[0]  = '{4'b1111, 8'd0,  8'd1, 8'd255, 8'd200, 0, 0,  1'b0};
      vecs[1]  = '{4'b0000, 8'd0,  8'd1, 8'd255, 8'd200, 1, 1,  1'b0};
      vecs[2]  = '{4'b0000, 8'd0,  8'd1, 8'd255, 8'd200, 2, 15, 1'b0};
      vecs[3]  = '{4'b0000, 8'd0,  8'd1, 8'd255, 8'd200, 3, 14, 1'b0};
      vecs[4]  = '{4'b0001, 8'd64, 8'd0, 8'd0,   8'd0,   0, 8,  1'b0};
      vecs[5]  = '{4'b0100, 8'd0,  8'd0, 8'd49,  8'd0,   2, 7,  1'b0};
      vecs[6]  = '{4'b0101, 8'd3,  8'd0, 8'd100, 8'd0,   0, 1,  1'b1};
      vecs[7]  = '{4'b0000, 8'd3,  8'd0, 8'd100, 8'd0,   2, 10, 1'b1};
      vecs[8]  = '{4'b0000, 8'd3,  8'd0, 8'd100, 8'd0,   0, 1,  1'b1};
      vecs[9]  = '{4'b0000, 8'd3,  8'd0, 8'd100, 8'd0,   2, 10, 1'b0};
      vecs[10] = '{4'b0000, 8'd3,  8'd0, 8'd100, 8'd0,   0, 1,  1'b0};

      reset    = 1'b1;
      req      = '0;
      req_data = '0;
      repeat (3) @(negedge clk);
      chk("rst_ack", int'(ack), 0);
      chk("rst_valid", int'(rsp_valid), 0);
      chk("rst_id", int'(rsp_id), 0);
      chk("rst_root", int'(rsp_root), 0);
      chk("rst_err", int'(rsp_err), 0);
      chk("rst_go", int'(eng_go), 0);
      chk("rst_in", int'(eng_in), 0);
      chk("rst_busy", int'(busy), 0);
      chk("rst_eng_reset", int'(eng_reset), 1);
      reset = 1'b0;

      for (int v = 0; v < 11; v++) begin
         req      = req | vecs[v].set_req;
         req_data = {vecs[v].d3, vecs[v].d2, vecs[v].d1, vecs[v].d0};
         do_job(vecs[v].exp_id, vecs[v].exp_root, 0, 6, vecs[v].hold);
      end
      chk("req_all_served", int'(req), 0);

      // engine never finishes: abort after TIMEOUT run cycles
      e_lat    = 1000;
      req_data = {8'd0, 8'd0, 8'd0, 8'd81};
      req      = 4'b0001;
      do_job(0, 0, 1, TIMEOUT, 1'b0);

      // completion on the final allowed run cycle beats the timeout
      e_lat    = TIMEOUT - 1;
      e_force9 = 1'b1;
      req      = 4'b0001;
      do_job(0, 9, 0, TIMEOUT, 1'b0);

      // reset in the middle of a run
      e_lat    = 5;
      e_force9 = 1'b0;
      req_data = {8'd0, 8'd144, 8'd0, 8'd0};
      req      = 4'b0100;
      wn = 0;
      while (!eng_go && wn < 50) begin
         @(negedge clk);
         wn++;
      end
      chk("run_reached", int'(eng_go), 1);
      @(negedge clk);
      reset = 1'b1;
      req   = '0;
      @(negedge clk);
      chk("mid_rst_busy", int'(busy), 0);
      chk("mid_rst_go", int'(eng_go), 0);
      chk("mid_rst_eng_reset", int'(eng_reset), 1);
      chk("mid_rst_ack", int'(ack), 0);
      chk("mid_rst_valid", int'(rsp_valid), 0);
      chk("mid_rst_root", int'(rsp_root), 0);
      @(negedge clk);
      chk("mid_rst_eng_reset2", int'(eng_reset), 1);
      chk("mid_rst_ack2", int'(ack), 0);
      reset    = 1'b0;
      req_data = {8'd36, 8'd0, 8'd0, 8'd25};
      req      = 4'b1001;
      #1;
      chk("post_rst_eng_reset", int'(eng_reset), 0);
      do_job(0, 5, 0, 6, 1'b0);
      do_job(3, 6, 0, 6, 1'b0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
